// File: rtl/alu_pkg.sv
// Shared constants and FSM state encoding for the ALU result serializer.
package alu_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    REQ       = 2'b01,
    WAIT_DONE = 2'b10
  } state_t;
endpackage

// File: rtl/alu_result_serializer.sv
// Serializes a 2*WIDTH-bit ALU result to UART TX, LSB byte first; first byte valid one cycle after OUT_VALID.
// Each byte is held until TX_BUSY rises, then the next waits for TX_BUSY to fall; OUT_VALID while busy is dropped.
module alu_result_serializer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic [2*WIDTH-1:0]   ALU_OUT,
  input  logic                 OUT_VALID,
  input  logic                 SHORT_RES,
  input  logic                 TX_BUSY,
  output logic [BYTE_W-1:0]    TX_P_DATA,
  output logic                 TX_D_VLD,
  output logic                 SER_BUSY,
  output logic                 DONE,
  output logic                 DROP
);

  localparam int RW     = 2 * WIDTH;
  localparam int NBYTES = RW / BYTE_W;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  if ((RW % BYTE_W) != 0) begin : g_width_chk
    $error("alu_result_serializer: 2*WIDTH must be a multiple of 8");
  end

  state_t             state;
  logic [RW-1:0]      shreg;
  logic [CNT_W-1:0]   byte_cnt;
  logic [CNT_W-1:0]   last;

  // The low byte of the shift register is the byte presented to TX.
  assign TX_P_DATA = shreg[BYTE_W-1:0];

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      shreg    <= '0;
      byte_cnt <= '0;
      last     <= '0;
      TX_D_VLD <= 1'b0;
      SER_BUSY <= 1'b0;
      DONE     <= 1'b0;
      DROP     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      DROP <= 1'b0;
      case (state)
        IDLE: begin
          if (OUT_VALID) begin
            shreg    <= ALU_OUT;
            last     <= SHORT_RES ? '0 : CNT_W'(NBYTES - 1);
            byte_cnt <= '0;
            TX_D_VLD <= 1'b1;
            SER_BUSY <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (OUT_VALID) DROP <= 1'b1;
          // Busy already high on entry counts as acceptance.
          if (TX_BUSY) begin
            TX_D_VLD <= 1'b0;
            state    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (OUT_VALID) DROP <= 1'b1;
          if (!TX_BUSY) begin
            if (byte_cnt == last) begin
              DONE     <= 1'b1;
              SER_BUSY <= 1'b0;
              state    <= IDLE;
            end else begin
              shreg    <= shreg >> BYTE_W;
              byte_cnt <= byte_cnt + CNT_W'(1);
              TX_D_VLD <= 1'b1;
              state    <= REQ;
            end
          end
        end
        default: begin
          TX_D_VLD <= 1'b0;
          SER_BUSY <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed plus randomized checks of the ALU result serializer against a byte-queue reference model.
module tb_alu_result_serializer;

  logic        clk;
  logic        RST;
  logic [31:0] ALU_OUT;
  logic        OUT_VALID;
  logic        SHORT_RES;
  logic        TX_BUSY;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        SER_BUSY;
  logic        DONE;
  logic        DROP;

  alu_result_serializer #(.WIDTH(16)) dut (
    .clk       (clk),
    .RST       (RST),
    .ALU_OUT   (ALU_OUT),
    .OUT_VALID (OUT_VALID),
    .SHORT_RES (SHORT_RES),
    .TX_BUSY   (TX_BUSY),
    .TX_P_DATA (TX_P_DATA),
    .TX_D_VLD  (TX_D_VLD),
    .SER_BUSY  (SER_BUSY),
    .DONE      (DONE),
    .DROP      (DROP)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int resp_dly  = 2;
  int resp_hold = 10;
  int stab_err  = 0;
  int sb_err    = 0;
  int win       = 0;
  int done_cnt  = 0;
  int drop_cnt  = 0;
  int w0, d0, dr0;
  logic prev_vld = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // UART TX model: accepts a presented byte after resp_dly cycles, stays busy resp_hold cycles.
  initial begin
    logic [7:0] seen;
    TX_BUSY = 1'b0;
    forever begin
      @(negedge clk);
      if (RST && TX_D_VLD === 1'b1 && !TX_BUSY) begin
        seen = TX_P_DATA;
        for (int i = 0; i < resp_dly && RST; i++) begin
          @(negedge clk);
          if (RST && (TX_D_VLD !== 1'b1 || TX_P_DATA !== seen)) stab_err++;
        end
        if (RST) begin
          TX_BUSY = 1'b1;
          got.push_back(TX_P_DATA);
          for (int i = 0; i < resp_hold && RST; i++) @(negedge clk);
        end
        TX_BUSY = 1'b0;
      end
    end
  end

  // Event counters, sampled just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (TX_D_VLD === 1'b1 && prev_vld !== 1'b1) win++;
      prev_vld = TX_D_VLD;
      if (DONE === 1'b1) done_cnt++;
      if (DROP === 1'b1) drop_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic start_xfer(input logic [31:0] d, input logic s, input bit align);
    exp_q.delete();
    for (int k = 0; k < (s ? 1 : 4); k++) exp_q.push_back(d[8*k +: 8]);
    got.delete();
    sb_err   = 0;
    stab_err = 0;
    if (align) @(negedge clk);
    w0  = win;
    d0  = done_cnt;
    dr0 = drop_cnt;
    ALU_OUT   = d;
    SHORT_RES = s;
    OUT_VALID = 1'b1;
    @(negedge clk);
    OUT_VALID = 1'b0;
    SHORT_RES = 1'b0;
  endtask

  task automatic finish_xfer(input string tag);
    int n;
    for (n = 0; n < 3000; n++) begin
      if (DONE === 1'b1) break;
      if (SER_BUSY !== 1'b1) sb_err++;
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, 32'(n < 3000), 32'd1);
    chk({tag, "_ser_busy_held"}, 32'(sb_err), 32'd0);
    chk({tag, "_ser_busy_at_done"}, 32'(SER_BUSY), 32'd0);
    chk({tag, "_nbytes"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    chk({tag, "_vld_windows"}, 32'(win - w0), 32'(exp_q.size()));
    chk({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_data_stable"}, 32'(stab_err), 32'd0);
  endtask

  task automatic idle_check(input string tag);
    repeat (5) @(negedge clk);
    chk({tag, "_no_extra_vld"}, 32'(win - w0), 32'(exp_q.size()));
    chk({tag, "_single_done"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_idle_vld"}, 32'(TX_D_VLD), 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] rd;
    ALU_OUT   = '0;
    OUT_VALID = 1'b0;
    SHORT_RES = 1'b0;
    RST       = 1'b1;
    #3 RST = 1'b0;
    #1;
    chk("rst_tx_p_data", 32'(TX_P_DATA), 32'd0);
    chk("rst_tx_d_vld",  32'(TX_D_VLD),  32'd0);
    chk("rst_ser_busy",  32'(SER_BUSY),  32'd0);
    chk("rst_done",      32'(DONE),      32'd0);
    chk("rst_drop",      32'(DROP),      32'd0);
    repeat (3) @(negedge clk);
    RST = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_no_vld",     32'(win), 32'd0);
    chk("idle_ser_busy",   32'(SER_BUSY), 32'd0);
    chk("idle_done_count", 32'(done_cnt), 32'd0);

    // Full 4-byte result
    resp_dly = 2; resp_hold = 10;
    start_xfer(32'hA1B2C3D4, 1'b0, 1'b1);
    finish_xfer("full");
    idle_check("full");

    // Short compare result
    start_xfer(32'h00000002, 1'b1, 1'b1);
    finish_xfer("short");
    idle_check("short");

    // OUT_VALID during byte 2 is dropped; OUT_VALID right after DONE is accepted
    start_xfer(32'hA1B2C3D4, 1'b0, 1'b1);
    for (n = 0; n < 500 && got.size() < 2; n++) @(negedge clk);
    chk("drop_reach_byte2", 32'(got.size() >= 2), 32'd1);
    ALU_OUT   = 32'h11112222;
    OUT_VALID = 1'b1;
    @(negedge clk);
    OUT_VALID = 1'b0;
    chk("drop_pulse_high", 32'(DROP), 32'd1);
    @(negedge clk);
    chk("drop_pulse_low", 32'(DROP), 32'd0);
    finish_xfer("drop_first");
    chk("drop_count", 32'(drop_cnt - dr0), 32'd1);
    start_xfer(32'h11112222, 1'b0, 1'b0);
    finish_xfer("after_done");
    chk("after_done_no_drop", 32'(drop_cnt - dr0), 32'd0);
    idle_check("after_done");

    // Reset while waiting for the first byte to complete
    rd = $urandom;
    start_xfer(rd, 1'b0, 1'b1);
    for (n = 0; n < 500 && got.size() < 1; n++) @(negedge clk);
    chk("rst_mid_reach_byte1", 32'(got.size() >= 1), 32'd1);
    @(negedge clk);
    #2 RST = 1'b0;
    #1;
    chk("rst_mid_tx_d_vld",  32'(TX_D_VLD),  32'd0);
    chk("rst_mid_ser_busy",  32'(SER_BUSY),  32'd0);
    chk("rst_mid_tx_p_data", 32'(TX_P_DATA), 32'd0);
    chk("rst_mid_done",      32'(DONE),      32'd0);
    repeat (4) @(negedge clk);
    RST = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
    start_xfer(~rd, 1'b0, 1'b1);
    finish_xfer("post_rst");
    idle_check("post_rst");

    // Slow TX acceptance: byte held stable across the whole wait
    resp_dly = 50; resp_hold = 3;
    start_xfer($urandom, 1'b0, 1'b1);
    finish_xfer("slow_tx");

    // Randomized results, modes and TX timing
    for (int t = 0; t < 12; t++) begin
      resp_dly  = int'($urandom_range(0, 4));
      resp_hold = int'($urandom_range(1, 5));
      start_xfer($urandom, 1'($urandom_range(0, 1)), 1'b1);
      finish_xfer($sformatf("rand%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
